// File: rtl/status_formatter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | status_formatter: streams one ASCII status line per request      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module status_formatter #(
  parameter int TERM_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cfg_status,
  input  logic        req,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [5:0] c_tail = (TERM_CRLF != 0) ? 6'd19 : 6'd18;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_ptr, w_ptr_nxt;
  logic [63:0] r_snap, w_snap_nxt;

  logic [5:0]  w_len_l, w_len_m, w_len_r;
  logic [5:0]  w_sp1, w_m0, w_sp2, w_r0, w_sp3, w_base, w_last;
  logic [5:0]  w_off_m, w_off_r, w_rel;
  logic [4:0]  w_cnt, w_ones;
  logic [1:0]  w_tens;
  logic [7:0]  w_byte;
  logic        w_unused_bits;

  function automatic logic [7:0] rot_char(input logic [2:0] code, input logic [1:0] idx);
    case (code)
      3'd0, 3'd1, 3'd2: rot_char = "I";
      3'd3:             rot_char = (idx == 2'd0) ? "I" : "V";
      3'd4:             rot_char = "V";
      default:          rot_char = "?";
    endcase
  endfunction

  function automatic logic [5:0] rot_len(input logic [2:0] code);
    case (code)
      3'd1, 3'd3: rot_len = 6'd2;
      3'd2:       rot_len = 6'd3;
      default:    rot_len = 6'd1;
    endcase
  endfunction

  function automatic logic [7:0] letter(input logic [4:0] v);
    letter = (v < 5'd26) ? (8'h41 + {3'b000, v}) : 8'h3F;
  endfunction

  // Rotor names are variable length, so field boundaries move with the snapshot.
  assign w_len_l = rot_len(r_snap[63:61]);
  assign w_len_m = rot_len(r_snap[60:58]);
  assign w_len_r = rot_len(r_snap[57:55]);
  assign w_sp1   = w_len_l;
  assign w_m0    = w_sp1 + 6'd1;
  assign w_sp2   = w_m0 + w_len_m;
  assign w_r0    = w_sp2 + 6'd1;
  assign w_sp3   = w_r0 + w_len_r;
  assign w_base  = w_sp3 + 6'd1;
  assign w_last  = w_base + c_tail;
  assign w_off_m = r_ptr - w_m0;
  assign w_off_r = r_ptr - w_r0;
  assign w_rel   = r_ptr - w_base;
  assign w_cnt   = r_snap[24:20];
  assign w_unused_bits = ^r_snap[4:0];

  always_comb begin
    w_tens = 2'd0;
    w_ones = w_cnt;
    if (w_cnt >= 5'd30) begin
      w_tens = 2'd3;
      w_ones = w_cnt - 5'd30;
    end else if (w_cnt >= 5'd20) begin
      w_tens = 2'd2;
      w_ones = w_cnt - 5'd20;
    end else if (w_cnt >= 5'd10) begin
      w_tens = 2'd1;
      w_ones = w_cnt - 5'd10;
    end
  end

  always_comb begin
    w_byte = 8'h20;
    if (r_ptr < w_sp1) begin
      w_byte = rot_char(r_snap[63:61], r_ptr[1:0]);
    end else if (r_ptr == w_sp1) begin
      w_byte = 8'h20;
    end else if (r_ptr < w_sp2) begin
      w_byte = rot_char(r_snap[60:58], w_off_m[1:0]);
    end else if (r_ptr == w_sp2) begin
      w_byte = 8'h20;
    end else if (r_ptr < w_sp3) begin
      w_byte = rot_char(r_snap[57:55], w_off_r[1:0]);
    end else if (r_ptr == w_sp3) begin
      w_byte = 8'h20;
    end else begin
      case (w_rel)
        6'd0:  w_byte = "R";
        6'd1:  w_byte = letter(r_snap[54:50]);
        6'd2:  w_byte = letter(r_snap[49:45]);
        6'd3:  w_byte = letter(r_snap[44:40]);
        6'd5:  w_byte = "G";
        6'd6:  w_byte = letter(r_snap[39:35]);
        6'd7:  w_byte = letter(r_snap[34:30]);
        6'd8:  w_byte = letter(r_snap[29:25]);
        6'd10: w_byte = "P";
        6'd11: w_byte = 8'h30 + {6'd0, w_tens};
        6'd12: w_byte = 8'h30 + {3'd0, w_ones};
        6'd14: w_byte = "W";
        6'd15: w_byte = letter(r_snap[19:15]);
        6'd16: w_byte = letter(r_snap[14:10]);
        6'd17: w_byte = letter(r_snap[9:5]);
        6'd18: w_byte = (TERM_CRLF != 0) ? 8'h0D : 8'h0A;
        6'd19: w_byte = 8'h0A;
        default: w_byte = 8'h20;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 6'd0;
      r_snap  <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_snap  <= w_snap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_snap_nxt  = r_snap;
    busy        = 1'b0;
    done        = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_snap_nxt  = cfg_status;
          w_ptr_nxt   = 6'd0;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = w_byte;
        if (tx_ready) begin
          if (r_ptr == w_last) begin
            w_ptr_nxt   = 6'd0;
            w_state_nxt = S_FIN;
          end else begin
            w_ptr_nxt = r_ptr + 6'd1;
          end
        end
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_status_formatter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_status_formatter: bench for status_formatter (CRLF and LF)    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_status_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cfg_status;
  logic        req;
  logic        tx_ready;
  logic        busy, done, tx_valid;
  logic [7:0]  tx_data;
  logic        busy_lf, done_lf, tx_valid_lf;
  logic [7:0]  tx_data_lf;

  int vectors = 0;
  int miscompares = 0;
  int done_main_cnt = 0;
  int done_lf_cnt = 0;
  int lat_main;
  logic [7:0] q_main[$];
  logic [7:0] q_lf[$];
  bit r_stalled = 1'b0;
  logic [7:0] r_last = 8'h00;

  always #5 clk = ~clk;

  status_formatter #(.TERM_CRLF(1)) u_dut (
    .clk(clk), .rst(rst), .cfg_status(cfg_status), .req(req),
    .busy(busy), .done(done), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  status_formatter #(.TERM_CRLF(0)) u_dut_lf (
    .clk(clk), .rst(rst), .cfg_status(cfg_status), .req(req),
    .busy(busy_lf), .done(done_lf), .tx_data(tx_data_lf), .tx_valid(tx_valid_lf),
    .tx_ready(tx_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: builds the whole line as a string.
  function automatic string rot_s(input int c);
    case (c)
      0: return "I";
      1: return "II";
      2: return "III";
      3: return "IV";
      4: return "V";
      default: return "?";
    endcase
  endfunction

  function automatic string let_s(input int v);
    if (v < 26) return $sformatf("%c", 65 + v);
    return "?";
  endfunction

  function automatic string model(input logic [63:0] w, input bit crlf);
    int cnt;
    string term;
    cnt  = int'(w[24:20]);
    term = crlf ? "\r\n" : "\n";
    return {rot_s(int'(w[63:61])), " ", rot_s(int'(w[60:58])), " ", rot_s(int'(w[57:55])),
            " R", let_s(int'(w[54:50])), let_s(int'(w[49:45])), let_s(int'(w[44:40])),
            " G", let_s(int'(w[39:35])), let_s(int'(w[34:30])), let_s(int'(w[29:25])),
            " P", $sformatf("%0d%0d", cnt / 10, cnt % 10),
            " W", let_s(int'(w[19:15])), let_s(int'(w[14:10])), let_s(int'(w[9:5])), term};
  endfunction

  function automatic logic [63:0] mk(input int rl, rm, rr, il, im, ir, gl, gm, gr, cnt, pl, pm, pr);
    return {3'(rl), 3'(rm), 3'(rr), 5'(il), 5'(im), 5'(ir), 5'(gl), 5'(gm), 5'(gr),
            5'(cnt), 5'(pl), 5'(pm), 5'(pr), 5'd0};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (r_stalled) begin
        check("stall_valid", {63'd0, tx_valid}, 64'd1);
        check("stall_data", {56'd0, tx_data}, {56'd0, r_last});
      end
      if (tx_valid && tx_ready) q_main.push_back(tx_data);
      r_stalled = tx_valid && !tx_ready;
      r_last    = tx_data;
      if (done) done_main_cnt++;
      if (tx_valid_lf && tx_ready) q_lf.push_back(tx_data_lf);
      if (done_lf) done_lf_cnt++;
    end else begin
      r_stalled = 1'b0;
    end
  end

  task automatic cmp_q(input string tag, input bit sel_lf, input string exp);
    int sz;
    logic [63:0] obs;
    sz = sel_lf ? q_lf.size() : q_main.size();
    check({tag, "_len"}, 64'(sz), 64'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      if (i < sz) obs = {56'd0, (sel_lf ? q_lf[i] : q_main[i])};
      else        obs = 64'hdead;
      check(tag, obs, {56'd0, exp[i]});
    end
  endtask

  task automatic run_line(input logic [63:0] word, input bit rnd_ready, input bit rnd_cfg, input bit rnd_req);
    int dm0, dl0;
    bit seen_m, seen_l;
    q_main.delete();
    q_lf.delete();
    dm0 = done_main_cnt;
    dl0 = done_lf_cnt;
    seen_m = 1'b0;
    seen_l = 1'b0;
    lat_main = -1;
    @(posedge clk); #1;
    cfg_status = word; req = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 0; n < 400 && !(seen_m && seen_l); n++) begin
      if (rnd_cfg) cfg_status = {$urandom, $urandom};
      req = (rnd_req && !seen_m && !seen_l) ? 1'($urandom_range(0, 1)) : 1'b0;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (n == 0) begin
        check("first_valid", {63'd0, tx_valid}, 64'd1);
        check("first_busy", {63'd0, busy}, 64'd1);
      end
      if (done && !seen_m) begin
        seen_m = 1'b1;
        lat_main = n;
      end
      if (done_lf) seen_l = 1'b1;
      @(posedge clk); #1;
    end
    req = 1'b0;
    tx_ready = 1'b1;
    check("done_seen", {63'd0, seen_m}, 64'd1);
    check("done_lf_seen", {63'd0, seen_l}, 64'd1);
    repeat (4) @(negedge clk);
    check("done_once", 64'(done_main_cnt - dm0), 64'd1);
    check("done_lf_once", 64'(done_lf_cnt - dl0), 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] factory;
    int d0;
    rst = 1'b1; req = 1'b0; tx_ready = 1'b1; cfg_status = 64'd0;
    factory = mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_data", {56'd0, tx_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset wins over a simultaneous request.
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b1; cfg_status = factory;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", {63'd0, busy}, 64'd0);
    check("rst_prio_valid", {63'd0, tx_valid}, 64'd0);

    run_line(factory, 1'b0, 1'b0, 1'b0);
    check("factory_latency", 64'(lat_main), 64'd29);
    cmp_q("factory", 1'b0, "I II III RAAA GAAA P00 WAAA\r\n");
    cmp_q("factory_lf", 1'b1, "I II III RAAA GAAA P00 WAAA\n");

    w = mk(4, 3, 1, 1, 2, 25, 16, 4, 21, 10, 0, 1, 2);
    run_line(w, 1'b0, 1'b0, 1'b0);
    cmp_q("mixed", 1'b0, "V IV II RBCZ GQEV P10 WABC\r\n");
    cmp_q("mixed_lf", 1'b1, "V IV II RBCZ GQEV P10 WABC\n");

    run_line(factory, 1'b1, 1'b0, 1'b0);
    cmp_q("backpressure", 1'b0, "I II III RAAA GAAA P00 WAAA\r\n");

    w = {$urandom, $urandom};
    run_line(w, 1'b1, 1'b1, 1'b1);
    cmp_q("snapshot", 1'b0, model(w, 1'b1));
    cmp_q("snapshot_lf", 1'b1, model(w, 1'b0));

    w = mk(7, 0, 0, 30, 0, 0, 0, 0, 0, 31, 0, 0, 0);
    run_line(w, 1'b0, 1'b0, 1'b0);
    cmp_q("invalid", 1'b0, "? I I R?AA GAAA P31 WAAA\r\n");

    repeat (6) begin
      w = {$urandom, $urandom};
      run_line(w, 1'b1, 1'b0, 1'b0);
      cmp_q("random", 1'b0, model(w, 1'b1));
      cmp_q("random_lf", 1'b1, model(w, 1'b0));
    end

    // Abort after the fifth transferred byte.
    q_main.delete();
    q_lf.delete();
    d0 = done_main_cnt;
    @(posedge clk); #1;
    cfg_status = factory; req = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", {63'd0, tx_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_bytes", 64'(q_main.size()), 64'd5);
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_main_cnt - d0), 64'd0);
    run_line(factory, 1'b0, 1'b0, 1'b0);
    cmp_q("after_abort", 1'b0, "I II III RAAA GAAA P00 WAAA\r\n");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
